// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the memory loader.
//   - state_t       : loader FSM states (CHECK/ERROR only with LOADER_CHECKSUM_EN)
//   - ADDR_W_DEF    : default memory address width
//   - MAX_WORDS_DEF : default per-phase length cap
//   - sat_len()     : clamp a requested length to the cap
//   - is_load_state(): states in which the host stream is accepted
// Optional feature macro: LOADER_CHECKSUM_EN
package mips_pkg;

   localparam int ADDR_W_DEF    = 7;
   localparam int MAX_WORDS_DEF = 128;

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_I = 3'd1,
      ST_LOAD_D = 3'd2,
      ST_CHECK  = 3'd3,
      ST_RUN    = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_I = 3'd1,
      ST_LOAD_D = 3'd2,
      ST_RUN    = 3'd4
   } state_t;
`endif

   function automatic logic [8:0] sat_len(input logic [7:0] len, input int max_words);
      if (int'({24'd0, len}) > max_words) return 9'(max_words);
      return {1'b0, len};
   endfunction

   function automatic logic is_load_state(input state_t s);
      logic r;
      r = (s == ST_LOAD_I) || (s == ST_LOAD_D);
`ifdef LOADER_CHECKSUM_EN
      r = r || (s == ST_CHECK);
`endif
      return r;
   endfunction

endpackage

// File: rtl/load_addr_ctr.sv
// load_addr_ctr: per-phase word counter for the loader.
//   clk, reset : clock, async active-high reset
//   clr, len   : restart a phase with length len (saturated to MAX_WORDS)
//   inc        : one word transferred
//   idx        : current word index (starts at 0, never wraps)
//   last       : the next transfer is the final one of the phase
// Remaining words are kept as a down-counter; the index runs alongside.
module load_addr_ctr
   import mips_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [7:0]        len,
   input  logic              inc,
   output logic [ADDR_W-1:0] idx,
   output logic              last
);

   logic [8:0]        rem_q, rem_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   always_comb begin
      rem_d = rem_q;
      idx_d = idx_q;
      if (clr) begin
         rem_d = sat_len(len, MAX_WORDS);
         idx_d = '0;
      end else if (inc && (rem_q != 9'd0)) begin
         rem_d = rem_q - 9'd1;
         // hold at the top address instead of wrapping to 0
         if (idx_q != ADDR_W'(MAX_WORDS - 1)) idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         idx_q <= '0;
      end else begin
         rem_q <= rem_d;
         idx_q <= idx_d;
      end
   end

   assign idx  = idx_q;
   assign last = (rem_q == 9'd1);

endmodule

// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: loads instruction and data memories from a host word
// stream, then enables the processor.
//   clk, reset                       : clock, async active-high reset
//   start, i_len, d_len              : load request and phase lengths
//   host_valid, host_word/host_ready : host stream handshake
//   halt                             : return from RUN to IDLE
//   instruction/instructionAddress/instr_we : instruction memory write port
//   data/dataAddress/writeEnable            : data memory write port
//   cpu_run, busy, load_err          : status
// Optional feature macro: LOADER_CHECKSUM_EN (checksum word after the load)
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_I  | streaming words into instruction memory
// LOAD_D  | streaming words into data memory
// CHECK   | waiting for the checksum word (macro only)
// RUN     | processor enabled
// ERROR   | checksum mismatch, load_err high (macro only)
module mem_load_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        i_len,
   input  logic [7:0]        d_len,
   input  logic              host_valid,
   input  logic [31:0]       host_word,
   output logic              host_ready,
   input  logic              halt,
   output logic [31:0]       instruction,
   output logic [ADDR_W-1:0] instructionAddress,
   output logic              instr_we,
   output logic [31:0]       data,
   output logic [ADDR_W-1:0] dataAddress,
   output logic              writeEnable,
   output logic              cpu_run,
   output logic              busy,
   output logic              load_err
);

`ifdef LOADER_CHECKSUM_EN
   localparam state_t ST_POST = ST_CHECK;
`else
   localparam state_t ST_POST = ST_RUN;
`endif

   state_t            state_q, state_d;
   logic [7:0]        d_len_q, d_len_d;
   logic              instr_we_q, instr_we_d;
   logic [31:0]       instruction_q, instruction_d;
   logic [ADDR_W-1:0] iaddr_q, iaddr_d;
   logic              we_q, we_d;
   logic [31:0]       data_q, data_d;
   logic [ADDR_W-1:0] daddr_q, daddr_d;
   logic              cpu_run_q, cpu_run_d;
   logic              busy_q, busy_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       sum_q, sum_d;
   logic              load_err_q, load_err_d;
`endif

   logic              accept, xfer;
   logic              ctr_clr, ctr_inc, ctr_last;
   logic [7:0]        ctr_len;
   logic [ADDR_W-1:0] ctr_idx;

   load_addr_ctr #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .clr   (ctr_clr),
      .len   (ctr_len),
      .inc   (ctr_inc),
      .idx   (ctr_idx),
      .last  (ctr_last)
   );

   assign host_ready = is_load_state(state_q);

   always_comb begin
      state_d       = state_q;
      d_len_d       = d_len_q;
      instr_we_d    = 1'b0;
      instruction_d = instruction_q;
      iaddr_d       = iaddr_q;
      we_d          = 1'b0;
      data_d        = data_q;
      daddr_d       = daddr_q;
      ctr_clr       = 1'b0;
      ctr_inc       = 1'b0;
      ctr_len       = d_len_q;
      accept        = (state_q == ST_IDLE);
`ifdef LOADER_CHECKSUM_EN
      sum_d         = sum_q;
      // a new start also clears a checksum failure
      if (state_q == ST_ERROR) accept = 1'b1;
`endif
      accept        = accept && start;
      xfer          = host_valid && host_ready;

      if (accept) begin
         d_len_d = d_len;
         ctr_clr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         sum_d   = '0;
`endif
         if (i_len != 8'd0) begin
            ctr_len = i_len;
            state_d = ST_LOAD_I;
         end else if (d_len != 8'd0) begin
            ctr_len = d_len;
            state_d = ST_LOAD_D;
         end else begin
            state_d = ST_POST;
         end
      end else begin
         case (state_q)
            ST_LOAD_I: if (xfer) begin
               instr_we_d    = 1'b1;
               instruction_d = host_word;
               iaddr_d       = ctr_idx;
               ctr_inc       = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               sum_d         = sum_q + host_word;
`endif
               if (ctr_last) begin
                  ctr_clr = 1'b1;
                  state_d = (d_len_q != 8'd0) ? ST_LOAD_D : ST_POST;
               end
            end
            ST_LOAD_D: if (xfer) begin
               we_d    = 1'b1;
               data_d  = host_word;
               daddr_d = ctr_idx;
               ctr_inc = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = sum_q + host_word;
`endif
               if (ctr_last) state_d = ST_POST;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: if (xfer) state_d = (host_word == sum_q) ? ST_RUN : ST_ERROR;
`endif
            ST_RUN: if (halt) state_d = ST_IDLE;
            default: ;
         endcase
      end

      // cpu_run lags entry into RUN by one cycle so it follows the last strobe
      cpu_run_d  = (state_q == ST_RUN) && (state_d == ST_RUN);
      busy_d     = is_load_state(state_d);
`ifdef LOADER_CHECKSUM_EN
      load_err_d = (state_d == ST_ERROR);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         d_len_q       <= '0;
         instr_we_q    <= 1'b0;
         instruction_q <= '0;
         iaddr_q       <= '0;
         we_q          <= 1'b0;
         data_q        <= '0;
         daddr_q       <= '0;
         cpu_run_q     <= 1'b0;
         busy_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q         <= '0;
         load_err_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         d_len_q       <= d_len_d;
         instr_we_q    <= instr_we_d;
         instruction_q <= instruction_d;
         iaddr_q       <= iaddr_d;
         we_q          <= we_d;
         data_q        <= data_d;
         daddr_q       <= daddr_d;
         cpu_run_q     <= cpu_run_d;
         busy_q        <= busy_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q         <= sum_d;
         load_err_q    <= load_err_d;
`endif
      end
   end

   assign instr_we           = instr_we_q;
   assign instruction        = instruction_q;
   assign instructionAddress = iaddr_q;
   assign writeEnable        = we_q;
   assign data               = data_q;
   assign dataAddress        = daddr_q;
   assign cpu_run            = cpu_run_q;
   assign busy               = busy_q;
`ifdef LOADER_CHECKSUM_EN
   assign load_err           = load_err_q;
`else
   assign load_err           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_ctrl.sv
// tb_mem_load_ctrl: directed bench for mem_load_ctrl with a write-list
// model and a per-cycle compare process.
module tb_mem_load_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  i_len = '0, d_len = '0;
   logic        host_valid = 1'b0;
   logic [31:0] host_word = '0;
   logic        host_ready;
   logic        halt = 1'b0;
   logic [31:0] instruction, data;
   logic [6:0]  instructionAddress, dataAddress;
   logic        instr_we, writeEnable, cpu_run, busy, load_err;

   mem_load_ctrl #(.ADDR_W(7), .MAX_WORDS(128)) dut (
      .clk(clk), .reset(reset), .start(start), .i_len(i_len), .d_len(d_len),
      .host_valid(host_valid), .host_word(host_word), .host_ready(host_ready),
      .halt(halt), .instruction(instruction), .instructionAddress(instructionAddress),
      .instr_we(instr_we), .data(data), .dataAddress(dataAddress),
      .writeEnable(writeEnable), .cpu_run(cpu_run), .busy(busy), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_ia[$];
   logic [31:0] exp_id[$];
   int exp_da[$];
   logic [31:0] exp_dd[$];
   logic [31:0] exp_sum;
   int n_is = 0, n_ds = 0, last_strobe_cyc = 0;
   logic [31:0] last_instr = '0, last_data = '0;
   logic [6:0]  last_ia = '0, last_da = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wv(input logic [31:0] base, input logic [31:0] step, input int k);
      return base + step * 32'(k);
   endfunction

   // per-cycle compare against the expected write lists
   always @(posedge clk) begin
      #1;
      cyc++;
      if (reset) begin
         last_instr = '0; last_data = '0; last_ia = '0; last_da = '0;
      end else begin
         if (instr_we) begin
            if (exp_ia.size() == 0) chk("unexpected_instr_strobe", 32'd1, 32'd0);
            else begin
               chk("instr_addr", 32'(instructionAddress), 32'(exp_ia[0]));
               chk("instr_data", instruction, exp_id[0]);
               void'(exp_ia.pop_front());
               void'(exp_id.pop_front());
            end
            n_is++; last_strobe_cyc = cyc;
            last_instr = instruction; last_ia = instructionAddress;
         end else begin
            chk("instr_hold_addr", 32'(instructionAddress), 32'(last_ia));
            chk("instr_hold_data", instruction, last_instr);
         end
         if (writeEnable) begin
            if (exp_da.size() == 0) chk("unexpected_data_strobe", 32'd1, 32'd0);
            else begin
               chk("data_addr", 32'(dataAddress), 32'(exp_da[0]));
               chk("data_data", data, exp_dd[0]);
               void'(exp_da.pop_front());
               void'(exp_dd.pop_front());
            end
            n_ds++; last_strobe_cyc = cyc;
            last_data = data; last_da = dataAddress;
         end else begin
            chk("data_hold_addr", 32'(dataAddress), 32'(last_da));
            chk("data_hold_data", data, last_data);
         end
         chk("cpu_run_during_load",
             32'(cpu_run && (instr_we || writeEnable || exp_ia.size() != 0 || exp_da.size() != 0)), 32'd0);
         chk("busy_eq_ready", 32'(busy), 32'(host_ready));
`ifndef LOADER_CHECKSUM_EN
         chk("load_err_tied", 32'(load_err), 32'd0);
`endif
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(host_ready), 0);
      chk({tag, "_instr_we"}, 32'(instr_we), 0);
      chk({tag, "_we"}, 32'(writeEnable), 0);
      chk({tag, "_cpu_run"}, 32'(cpu_run), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_load_err"}, 32'(load_err), 0);
      chk({tag, "_iaddr"}, 32'(instructionAddress), 0);
      chk({tag, "_instr"}, instruction, 0);
      chk({tag, "_daddr"}, 32'(dataAddress), 0);
      chk({tag, "_data"}, data, 0);
   endtask

   // queue the writes the load must produce, then pulse start
   task automatic start_load(input int il, input int dl, input logic [31:0] base, input logic [31:0] step);
      int si, sd;
      si = (il > 128) ? 128 : il;
      sd = (dl > 128) ? 128 : dl;
      exp_sum = '0;
      for (int k = 0; k < si; k++) begin
         exp_ia.push_back(k); exp_id.push_back(wv(base, step, k)); exp_sum += wv(base, step, k);
      end
      for (int k = 0; k < sd; k++) begin
         exp_da.push_back(k); exp_dd.push_back(wv(base, step, si + k)); exp_sum += wv(base, step, si + k);
      end
      @(negedge clk);
      start = 1'b1; i_len = 8'(il); d_len = 8'(dl);
      @(negedge clk);
      start = 1'b0;
   endtask

   // offer n words; pat gives host_valid per cycle (LSB first, repeating)
   task automatic feed(input int n, input logic [31:0] base, input logic [31:0] step,
                       input logic [7:0] pat, input int patlen);
      int sent = 0;
      int c = 0;
      logic v;
      while (sent < n && c < 2000) begin
         @(negedge clk);
         v = pat[c % patlen];
         host_valid = v;
         host_word  = wv(base, step, sent);
         if (v && host_ready) sent++;
         c++;
      end
      @(negedge clk);
      host_valid = 1'b0;
      if (sent < n) chk("feed_timeout_words", 32'(sent), 32'(n));
   endtask

   task automatic check_word();
`ifdef LOADER_CHECKSUM_EN
      feed(1, exp_sum, 0, 8'h01, 1);
`endif
   endtask

   task automatic wait_run(output int rise);
      int i;
      rise = -1;
      for (i = 0; i < 20; i++) begin
         if (cpu_run) break;
         @(negedge clk);
      end
      if (!cpu_run) chk("wait_run_timeout", 32'(cpu_run), 32'd1);
      rise = cyc;
   endtask

   task automatic do_halt();
      @(negedge clk); halt = 1'b1;
      @(negedge clk); halt = 1'b0;
      chk("halt_cpu_run", 32'(cpu_run), 0);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_ready", 32'(host_ready), 0);
      chk("pending_writes", 32'(exp_ia.size() + exp_da.size()), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rise, s0, is0, ds0;
      @(negedge clk);
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // two instruction words then one data word, contiguous stream
      n_is = 0; n_ds = 0;
      start_load(2, 1, 32'hA, 32'd1);
      feed(3, 32'hA, 32'd1, 8'h01, 1);
      check_word();
      wait_run(rise);
      chk("t1_n_instr", 32'(n_is), 2);
      chk("t1_n_data", 32'(n_ds), 1);
      chk("t1_last_instr", instruction, 32'hB);
      chk("t1_last_iaddr", 32'(instructionAddress), 1);
      chk("t1_data", data, 32'hC);
      chk("t1_daddr", 32'(dataAddress), 0);
`ifndef LOADER_CHECKSUM_EN
      chk("t1_run_lag", 32'(rise - last_strobe_cyc), 1);
`endif
      // start is ignored while running
      @(negedge clk); start = 1'b1; i_len = 8'd5; d_len = 8'd5;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t1_run_ignores_start", 32'(cpu_run), 1);
      chk("t1_run_not_busy", 32'(busy), 0);
      do_halt();

      // both lengths zero
      n_is = 0; n_ds = 0;
      start_load(0, 0, 32'h0, 32'd0);
      s0 = cyc;
      check_word();
      wait_run(rise);
`ifndef LOADER_CHECKSUM_EN
      chk("t2_run_latency_ok", 32'((rise - s0) <= 1), 1);
`endif
      chk("t2_no_strobes", 32'(n_is + n_ds), 0);
      do_halt();

      // stalled stream: valid 1,0,0,1,1
      n_is = 0; n_ds = 0;
      start_load(3, 0, 32'h300, 32'd3);
      feed(3, 32'h300, 32'd3, 8'h19, 5);
      check_word();
      wait_run(rise);
      chk("t3_n_instr", 32'(n_is), 3);
      chk("t3_last_iaddr", 32'(instructionAddress), 2);
      chk("t3_last_instr", instruction, 32'h306);
      do_halt();

      // oversize instruction length saturates
      n_is = 0; n_ds = 0;
      start_load(200, 1, 32'h1000_0000, 32'd7);
      feed(129, 32'h1000_0000, 32'd7, 8'h01, 1);
      check_word();
      wait_run(rise);
      chk("t4_n_instr", 32'(n_is), 128);
      chk("t4_last_iaddr", 32'(instructionAddress), 127);
      chk("t4_n_data", 32'(n_ds), 1);
      do_halt();

      // data-only, oversize, with stalls
      n_is = 0; n_ds = 0;
      start_load(0, 130, 32'h5555_0000, 32'd1);
      feed(128, 32'h5555_0000, 32'd1, 8'h05, 3);
      check_word();
      wait_run(rise);
      chk("t5_n_data", 32'(n_ds), 128);
      chk("t5_last_daddr", 32'(dataAddress), 127);
      chk("t5_n_instr", 32'(n_is), 0);
      do_halt();

      // reset in the middle of a load
      n_is = 0; n_ds = 0;
      start_load(4, 0, 32'h400, 32'd1);
      feed(2, 32'h400, 32'd1, 8'h01, 1);
      is0 = n_is; ds0 = n_ds;
      chk("t6_strobes_before_reset", 32'(is0), 2);
      reset = 1'b1;
      #1;
      chk_all_zero("t6_reset");
      exp_ia.delete(); exp_id.delete(); exp_da.delete(); exp_dd.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      host_valid = 1'b1; host_word = 32'hDEAD;
      repeat (6) @(negedge clk);
      host_valid = 1'b0;
      chk("t6_no_later_strobes", 32'(n_is + n_ds - is0 - ds0), 0);
      chk("t6_idle_ready", 32'(host_ready), 0);
      chk("t6_idle_run", 32'(cpu_run), 0);

`ifdef LOADER_CHECKSUM_EN
      // good checksum
      start_load(2, 0, 32'd1, 32'd1);
      feed(2, 32'd1, 32'd1, 8'h01, 1);
      feed(1, 32'd3, 32'd0, 8'h01, 1);
      wait_run(rise);
      chk("t7_good_sum_run", 32'(cpu_run), 1);
      do_halt();
      // bad checksum
      start_load(2, 0, 32'd1, 32'd1);
      feed(2, 32'd1, 32'd1, 8'h01, 1);
      feed(1, 32'd4, 32'd0, 8'h01, 1);
      repeat (2) @(negedge clk);
      chk("t7_bad_sum_err", 32'(load_err), 1);
      chk("t7_bad_sum_run", 32'(cpu_run), 0);
      chk("t7_bad_sum_ready", 32'(host_ready), 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t7_err_cleared", 32'(load_err), 0);
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_load_ctrl.md
MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the memory address width (128 words per memory).
REQ-002 Parameter MAX_WORDS, default 128, SHALL set the per-phase length cap (2**ADDR_W).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous and active-high.
REQ-005 start  in  1  SHALL be a one-cycle load request, honoured only in IDLE.
REQ-006 i_len, d_len  in  8 each  SHALL give the instruction and data word counts, latched on an accepted start.
REQ-007 host_valid  in  1; host_word  in  32  SHALL form the host stream; host_ready  out  1 SHALL be the controller's acceptance.
REQ-008 halt  in  1  SHALL request return from RUN to IDLE.
REQ-009 instruction  out  32; instructionAddress  out  ADDR_W; instr_we  out  1  SHALL drive the instruction-memory write port.
REQ-010 data  out  32; dataAddress  out  ADDR_W; writeEnable  out  1  SHALL drive the data-memory write port.
REQ-011 cpu_run  out  1; busy  out  1; load_err  out  1  SHALL report processor enable, load in progress and checksum failure.

Function
REQ-012 States SHALL be IDLE, LOAD_I, LOAD_D, CHECK (macro only), RUN, ERROR.
REQ-013 IDLE+start SHALL go to LOAD_I if i_len!=0, else LOAD_D if d_len!=0, else RUN (CHECK first with macro).
REQ-014 Lengths >MAX_WORDS SHALL saturate to MAX_WORDS; 0 SHALL skip the phase.
REQ-015 host_ready SHALL be 1 exactly in LOAD_I, LOAD_D and CHECK, decoded from registered state.
REQ-016 A transfer SHALL occur on a rising edge with host_valid&&host_ready; host_valid low SHALL stall without penalty.
REQ-017 Each transfer in LOAD_I SHALL produce, on the next cycle, instr_we=1 for one cycle with instruction=host_word and instructionAddress=word index; LOAD_D likewise on writeEnable/data/dataAddress.
REQ-018 Word index SHALL start at 0 per phase and increment by 1 per transfer; it SHALL never wrap (last index MAX_WORDS-1).
REQ-019 After the len-th transfer the state SHALL advance on the same edge (LOAD_I->LOAD_D/CHECK/RUN as per REQ-013 skip rules).
REQ-020 cpu_run SHALL be 1 only in RUN and SHALL rise no earlier than the cycle after the final write strobe.
REQ-021 RUN+halt SHALL go to IDLE with cpu_run=0 next cycle; start in any non-IDLE state SHALL be ignored.
REQ-022 busy SHALL be 1 in LOAD_I, LOAD_D, CHECK.
REQ-023 Write-port address/data outputs SHALL hold their last values when no strobe is active.

Reset
REQ-024 Reset SHALL force IDLE; host_ready, instr_we, writeEnable, cpu_run, busy, load_err, all addresses and data outputs SHALL be 0.
REQ-025 Reset during a load SHALL abort it with no further strobes; memory contents SHALL be left untouched.

Configuration
REQ-026 With LOADER_CHECKSUM_EN defined, a 32-bit modulo-2^32 sum of all loaded words SHALL be kept; CHECK SHALL accept one word, going to RUN on equality, else ERROR with load_err=1 until reset or start.
REQ-027 Without LOADER_CHECKSUM_EN, CHECK and ERROR SHALL not exist and load_err SHALL be tied 0.

Structure
REQ-028 The state enum, ADDR_W and MAX_WORDS defaults SHALL reside in shared package mips_pkg.
REQ-029 One sub-module, load_addr_ctr (saturating-length, non-wrapping index counter with terminal flag), SHALL be instantiated once and cleared per phase.

Verification
REQ-030 i_len=2, d_len=1, words A,B,C contiguous -> instr_we at addr 0,1 (A,B), writeEnable at addr 0 (C), cpu_run=1 one cycle after last strobe.
REQ-031 i_len=0, d_len=0 -> RUN within 1 cycle (no macro), no strobes.
REQ-032 i_len=3, host_valid toggling 1,0,0,1,1 -> exactly 3 strobes, addresses 0,1,2, no duplicates.
REQ-033 i_len=200 -> exactly 128 instruction writes, last addr 127, then next phase.
REQ-034 Reset asserted after 2 of 4 words -> all outputs 0 same cycle, IDLE, no later strobes.
REQ-035 With LOADER_CHECKSUM_EN, words 1,2 then check 3 -> RUN; check 4 -> ERROR, load_err=1, cpu_run=0.
